// File: rtl/ipf_bo_engine_if.sv
// Streaming pixel interface of the band-offset engine: upstream pixel/parameter
// inputs with in_en/busy flow control, and downstream addressed pixel outputs.
interface ipf_bo_engine_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14,
  parameter int XY_W   = 4
);
  logic              in_en;
  logic [PIX_W-1:0]  din;
  logic [1:0]        ipf_type;
  logic [4:0]        ipf_band_pos;
  logic              ipf_wo_class;
  logic [15:0]       ipf_offset;
  logic [XY_W-1:0]   lcu_x;
  logic [XY_W-1:0]   lcu_y;
  logic [1:0]        lcu_size;
  logic              busy;
  logic              out_en;
  logic [PIX_W-1:0]  dout;
  logic [ADDR_W-1:0] dout_addr;
  logic              finish;

  modport master (
    output in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size,
    input  busy, out_en, dout, dout_addr, finish
  );

  modport slave (
    input  in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size,
    output busy, out_en, dout, dout_addr, finish
  );
endinterface

// File: rtl/ipf_bo_engine.sv
// Band-offset filter stage: per-LCU band/uniform offset with clipping, two-stage
// pipeline, absolute raster addressing and end-of-frame signalling.
module ipf_bo_engine #(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int XY_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  ipf_bo_engine_if.slave bus
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int OSH   = PIX_W - 8;

  typedef enum logic [1:0] {ST_RUN, ST_GAP, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [1:0]        type_q, type_d;
  logic [4:0]        bp_q, bp_d;
  logic              wo_q, wo_d;
  logic [15:0]       off_q, off_d;
  logic [XY_W-1:0]   lx_q, lx_d, ly_q, ly_d;
  logic [2:0]        sh_q, sh_d;

  logic              v1_q, v1_d, last1_q, last1_d;
  logic [PIX_W-1:0]  din1_q, din1_d;
  logic [3:0]        off1_q, off1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;

  logic              v2_q, v2_d, last2_q, last2_d, fin_q, fin_d;
  logic [PIX_W-1:0]  dout_q, dout_d;
  logic [ADDR_W-1:0] addr2_q, addr2_d;

  logic              accept, first, px_end, py_end, frame_last, apply;
  logic [1:0]        type_e;
  logic [4:0]        bp_e, band, k;
  logic              wo_e;
  logic [15:0]       off_e;
  logic [XY_W-1:0]   lx_e, ly_e;
  logic [2:0]        sh_in, sh_e;
  logic [5:0]        smax;
  logic [3:0]        osel;
  logic signed [PIX_W+1:0] offs, sum;

  always_comb begin
    case (bus.lcu_size)
      2'd1:    sh_in = 3'd5;
      2'd2:    sh_in = 3'd6;
      default: sh_in = 3'd4;
    endcase

    // On LCU pixel 0 the live inputs are used directly, since they are only
    // being latched at this same edge.
    first  = (px_q == '0) && (py_q == '0);
    type_e = first ? bus.ipf_type     : type_q;
    bp_e   = first ? bus.ipf_band_pos : bp_q;
    wo_e   = first ? bus.ipf_wo_class : wo_q;
    off_e  = first ? bus.ipf_offset   : off_q;
    lx_e   = first ? bus.lcu_x        : lx_q;
    ly_e   = first ? bus.lcu_y        : ly_q;
    sh_e   = first ? sh_in            : sh_q;

    smax       = 6'((7'd1 << sh_e) - 7'd1);
    px_end     = (px_q == smax);
    py_end     = (py_q == smax);
    frame_last = (cnt_q == CNT_W'(NPIX - 1));
    accept     = bus.in_en && (state_q == ST_RUN);

    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    cnt_d   = cnt_q;
    type_d  = type_q;
    bp_d    = bp_q;
    wo_d    = wo_q;
    off_d   = off_q;
    lx_d    = lx_q;
    ly_d    = ly_q;
    sh_d    = sh_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (frame_last)            state_d = ST_DONE;
          else if (px_end && py_end) state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_RUN;
      default: state_d = ST_DONE;
    endcase

    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      px_d  = px_end ? '0 : px_q + 1'b1;
      if (px_end) py_d = py_end ? '0 : py_q + 1'b1;
      if (first) begin
        type_d = bus.ipf_type;
        bp_d   = bus.ipf_band_pos;
        wo_d   = bus.ipf_wo_class;
        off_d  = bus.ipf_offset;
        lx_d   = bus.lcu_x;
        ly_d   = bus.lcu_y;
        sh_d   = sh_in;
      end
    end

    band  = bus.din[PIX_W-1 -: 5];
    k     = band - bp_e;
    apply = (type_e == 2'd1) && (wo_e || (k[4:2] == 3'b000));
    case (wo_e ? 2'd0 : k[1:0])
      2'd0:    osel = off_e[15:12];
      2'd1:    osel = off_e[11:8];
      2'd2:    osel = off_e[7:4];
      default: osel = off_e[3:0];
    endcase

    v1_d    = accept;
    last1_d = accept && frame_last;
    din1_d  = accept ? bus.din : din1_q;
    off1_d  = accept ? (apply ? osel : 4'd0) : off1_q;
    addr1_d = accept ? ADDR_W'((((32'(ly_e) << sh_e) + 32'(py_q)) * 32'(IMG_W))
                               + (32'(lx_e) << sh_e) + 32'(px_q))
                     : addr1_q;

    offs = $signed({{(PIX_W-2){off1_q[3]}}, off1_q}) <<< OSH;
    sum  = $signed({2'b00, din1_q}) + offs;

    v2_d    = v1_q;
    last2_d = last1_q;
    addr2_d = v1_q ? addr1_q : addr2_q;
    dout_d  = dout_q;
    if (v1_q) begin
      if (sum[PIX_W+1])  dout_d = '0;
      else if (sum[PIX_W]) dout_d = '1;
      else               dout_d = sum[PIX_W-1:0];
    end
    fin_d = v2_q && last2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      px_q    <= '0;
      py_q    <= '0;
      cnt_q   <= '0;
      type_q  <= '0;
      bp_q    <= '0;
      wo_q    <= 1'b0;
      off_q   <= '0;
      lx_q    <= '0;
      ly_q    <= '0;
      sh_q    <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      din1_q  <= '0;
      off1_q  <= '0;
      addr1_q <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      dout_q  <= '0;
      addr2_q <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      bp_q    <= bp_d;
      wo_q    <= wo_d;
      off_q   <= off_d;
      lx_q    <= lx_d;
      ly_q    <= ly_d;
      sh_q    <= sh_d;
      v1_q    <= v1_d;
      last1_q <= last1_d;
      din1_q  <= din1_d;
      off1_q  <= off1_d;
      addr1_q <= addr1_d;
      v2_q    <= v2_d;
      last2_q <= last2_d;
      dout_q  <= dout_d;
      addr2_q <= addr2_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.busy      = (state_q != ST_RUN);
  assign bus.out_en    = v2_q;
  assign bus.dout      = dout_q;
  assign bus.dout_addr = addr2_q;
  assign bus.finish    = fin_q;

endmodule

// File: tb/tb_ipf_bo_engine.sv
// Directed bench for ipf_bo_engine: an 8-bit and a 10-bit instance driven by a
// linear sequence of steps, with outputs captured and checked against fixed values.
module tb_ipf_bo_engine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ipf_bo_engine_if #(.PIX_W(8),  .ADDR_W(14), .XY_W(4)) b8 ();
  ipf_bo_engine_if #(.PIX_W(10), .ADDR_W(14), .XY_W(4)) b10 ();

  ipf_bo_engine #(.PIX_W(8), .IMG_W(128), .IMG_H(128), .ADDR_W(14), .XY_W(4))
    dut8 (.clk(clk), .reset(reset), .bus(b8));
  ipf_bo_engine #(.PIX_W(10), .IMG_W(128), .IMG_H(128), .ADDR_W(14), .XY_W(4))
    dut10 (.clk(clk), .reset(reset), .bus(b10));

  int errors = 0;
  int checks = 0;

  logic [7:0]  qd[$];
  logic [13:0] qa[$];
  logic [7:0]  ed[$];
  logic [13:0] ea[$];
  logic        seen [0:16383];
  int cyc = 0, fin_cnt = 0, fin_cyc = 0, last_out_cyc = 0, clash = 0;

  always @(negedge clk) begin
    cyc++;
    if (b8.out_en === 1'b1) begin
      qd.push_back(b8.dout);
      qa.push_back(b8.dout_addr);
      last_out_cyc = cyc;
    end
    if (b8.finish === 1'b1) begin
      fin_cnt++;
      fin_cyc = cyc;
      if (b8.out_en === 1'b1) clash++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set8(input logic [1:0] t, input logic [4:0] bp, input logic wo,
                      input logic [15:0] off, input logic [3:0] lx, input logic [3:0] ly,
                      input logic [1:0] sz);
    b8.ipf_type = t; b8.ipf_band_pos = bp; b8.ipf_wo_class = wo;
    b8.ipf_offset = off; b8.lcu_x = lx; b8.lcu_y = ly; b8.lcu_size = sz;
  endtask

  task automatic push8(input logic [7:0] d);
    int guard = 0;
    b8.din = d;
    b8.in_en = 1'b1;
    while (b8.busy === 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) chk("push8_busy_timeout", b8.busy, 0);
    @(negedge clk);
    b8.in_en = 1'b0;
  endtask

  task automatic push10(input logic [9:0] d);
    int guard = 0;
    b10.din = d;
    b10.in_en = 1'b1;
    while (b10.busy === 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) chk("push10_busy_timeout", b10.busy, 0);
    @(negedge clk);
    b10.in_en = 1'b0;
  endtask

  task automatic one8(input string tag, input logic [1:0] t, input logic [4:0] bp,
                      input logic wo, input logic [15:0] off, input logic [3:0] lx,
                      input logic [3:0] ly, input logic [1:0] sz, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic [13:0] exp_a);
    do_reset();
    set8(t, bp, wo, off, lx, ly, sz);
    push8(d);
    chk({tag, "_lat"}, b8.out_en, 0);
    @(negedge clk);
    chk({tag, "_en"}, b8.out_en, 1);
    chk({tag, "_dout"}, b8.dout, exp_d);
    chk({tag, "_addr"}, b8.dout_addr, exp_a);
  endtask

  task automatic check_lcu00(input string tag);
    int bd = 0, ba = 0;
    for (int i = 0; i < qd.size() && i < 256; i++) begin
      if (qd[i] !== 8'h80) bd++;
      if (qa[i] !== 14'((i / 16) * 128 + i % 16)) ba++;
    end
    chk({tag, "_dout"}, bd, 0);
    chk({tag, "_addr"}, ba, 0);
  endtask

  initial begin
    b8.in_en = 1'b0; b8.din = '0; set8(0, 0, 0, 0, 0, 0, 0);
    b10.in_en = 1'b0; b10.din = '0; b10.ipf_type = '0; b10.ipf_band_pos = '0;
    b10.ipf_wo_class = 1'b0; b10.ipf_offset = '0; b10.lcu_x = '0; b10.lcu_y = '0;
    b10.lcu_size = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", b8.busy, 0);
    chk("rst_out_en", b8.out_en, 0);
    chk("rst_dout", b8.dout, 0);
    chk("rst_addr", b8.dout_addr, 0);
    chk("rst_finish", b8.finish, 0);
    chk("rst_busy10", b10.busy, 0);
    reset = 1'b1;
    @(negedge clk);

    // Scenario 1: pass-through LCU(0,0); mid-LCU parameter changes must be ignored
    qd.delete(); qa.delete();
    set8(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      push8(8'h80);
      if (i == 0) set8(1, 16, 1, 16'h7777, 5, 5, 2);
    end
    chk("s1_busy_pulse", b8.busy, 1);
    @(negedge clk);
    chk("s1_busy_release", b8.busy, 0);
    repeat (3) @(negedge clk);
    chk("s1_count", qd.size(), 256);
    check_lcu00("s1");
    chk("s1_no_finish", fin_cnt, 0);

    // Band offset, clipping, wrap, uniform offset, type decode and addressing
    one8("bo_b16",   1, 16, 0, 16'h7F1C, 0, 0, 0, 8'h80, 8'h87, 0);
    one8("bo_b19",   1, 16, 0, 16'h7F1C, 0, 0, 0, 8'h98, 8'h94, 0);
    one8("bo_b8",    1, 16, 0, 16'h7F1C, 0, 0, 0, 8'h40, 8'h40, 0);
    one8("bo_b17",   1, 16, 0, 16'h7F1C, 0, 0, 0, 8'h88, 8'h87, 0);
    one8("bo_b18",   1, 16, 0, 16'h7F1C, 0, 0, 0, 8'h90, 8'h91, 0);
    one8("clip_hi",  1, 31, 0, 16'h7000, 0, 0, 0, 8'hFF, 8'hFF, 0);
    one8("clip_lo",  1,  0, 0, 16'h8000, 0, 0, 0, 8'h02, 8'h00, 0);
    one8("wrap_in",  1, 30, 0, 16'h1234, 0, 0, 0, 8'h08, 8'h0C, 0);
    one8("wrap_out", 1, 30, 0, 16'h1234, 0, 0, 0, 8'h10, 8'h10, 0);
    one8("wo_class", 1, 16, 1, 16'h3000, 0, 0, 0, 8'h40, 8'h43, 0);
    one8("type0",    0, 16, 0, 16'h7F1C, 0, 0, 0, 8'h80, 8'h80, 0);
    one8("type2",    2, 16, 0, 16'h7F1C, 0, 0, 0, 8'h80, 8'h80, 0);
    one8("type3",    3, 16, 1, 16'h7F1C, 0, 0, 0, 8'h80, 8'h80, 0);
    one8("addr32",   0,  0, 0, 16'h0000, 2, 3, 1, 8'h55, 8'h55, 14'd12352);
    one8("addr_sz3", 0,  0, 0, 16'h0000, 2, 3, 3, 8'h66, 8'h66, 14'd6176);

    // Scenario 5: 10-bit pixels, 64x64 LCU at (1,1), scaled offset, back-to-back pixels
    do_reset();
    b10.ipf_type = 2'd1; b10.ipf_band_pos = 5'd16; b10.ipf_wo_class = 1'b0;
    b10.ipf_offset = 16'h1000; b10.lcu_x = 4'd1; b10.lcu_y = 4'd1; b10.lcu_size = 2'd2;
    push10(10'h200);
    chk("p10_lat", b10.out_en, 0);
    b10.ipf_offset = 16'h0000; b10.lcu_x = 4'd0;
    push10(10'h210);
    chk("p10_en0", b10.out_en, 1);
    chk("p10_dout0", b10.dout, 10'h204);
    chk("p10_addr0", b10.dout_addr, 14'd8256);
    @(negedge clk);
    chk("p10_en1", b10.out_en, 1);
    chk("p10_dout1", b10.dout, 10'h214);
    chk("p10_addr1", b10.dout_addr, 14'd8257);

    do_reset();
    b10.ipf_band_pos = 5'd0; b10.ipf_offset = 16'h8000; b10.lcu_x = 4'd0;
    b10.lcu_y = 4'd0; b10.lcu_size = 2'd0;
    push10(10'h010);
    @(negedge clk);
    chk("p10_clip_lo", b10.dout, 10'h000);
    do_reset();
    b10.ipf_band_pos = 5'd31; b10.ipf_offset = 16'h7000;
    push10(10'h3FF);
    @(negedge clk);
    chk("p10_clip_hi", b10.dout, 10'h3FF);

    // Scenario 6: full frame of 16x16 LCUs, alternating pass-through and +1 uniform offset
    do_reset();
    qd.delete(); qa.delete(); ed.delete(); ea.delete();
    fin_cnt = 0; clash = 0;
    for (int ly = 0; ly < 8; ly++) begin
      for (int lx = 0; lx < 8; lx++) begin
        logic [1:0] t;
        t = ((lx + ly) % 2 == 1) ? 2'd1 : 2'd0;
        set8(t, 0, 1, 16'h1000, 4'(lx), 4'(ly), 0);
        for (int p = 0; p < 256; p++) begin
          logic [7:0] d;
          d = 8'(lx * 37 + ly * 11 + p * 3);
          ed.push_back((t == 2'd1) ? ((d == 8'hFF) ? 8'hFF : d + 8'd1) : d);
          ea.push_back(14'(((ly * 16 + p / 16) * 128) + lx * 16 + p % 16));
          push8(d);
        end
      end
    end
    repeat (4) @(negedge clk);
    chk("frm_count", qd.size(), 16384);
    begin
      int bd = 0, ba = 0, dup = 0;
      for (int i = 0; i < 16384; i++) seen[i] = 1'b0;
      for (int i = 0; i < qd.size() && i < 16384; i++) begin
        if (qd[i] !== ed[i]) bd++;
        if (qa[i] !== ea[i]) ba++;
        if (seen[qa[i]]) dup++;
        seen[qa[i]] = 1'b1;
      end
      chk("frm_dout", bd, 0);
      chk("frm_addr", ba, 0);
      chk("frm_addr_dup", dup, 0);
    end
    chk("frm_finish_once", fin_cnt, 1);
    chk("frm_finish_timing", fin_cyc, last_out_cyc + 1);
    chk("frm_finish_clash", clash, 0);
    chk("frm_busy_hold", b8.busy, 1);
    b8.in_en = 1'b1; b8.din = 8'h00;
    repeat (10) @(negedge clk);
    b8.in_en = 1'b0;
    chk("frm_busy_stay", b8.busy, 1);
    chk("frm_no_extra", qd.size(), 16384);
    chk("frm_finish_still", fin_cnt, 1);

    // Reset after 1000 pixels discards in-flight data; restart begins at LCU pixel 0
    do_reset();
    chk("rr_busy_clear", b8.busy, 0);
    qd.delete(); qa.delete();
    for (int i = 0; i < 1000; i++) begin
      if (i % 256 == 0) set8(0, 0, 0, 0, 4'(i / 256), 0, 0);
      push8(8'h11);
    end
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rr_out_en_in_reset", b8.out_en, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rr_count", qd.size(), 999);
    if (qa.size() == 999) chk("rr_last_addr", qa[998], 14'd1846);
    qd.delete(); qa.delete();
    set8(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) push8(8'h80);
    repeat (4) @(negedge clk);
    chk("rr_restart_count", qd.size(), 256);
    check_lcu00("rr_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ipf_bo_engine.md
Name: ipf_bo_engine

Overview:
- Parametrised band-offset (BO) filter stage of the IPF pipeline, generalised in pixel depth, image dimensions and LCU size.
- Accepts raster-ordered pixels one LCU at a time, using the same in_en/busy streaming handshake as the IPF top.
- Applies a per-LCU band or uniform offset with clipping and emits each result with its absolute frame address.
- Asserts finish after the last pixel of the frame has been output.

Parameters:
PIX_W, 8, pixel bit depth (8..12)
IMG_W, 128, frame width in pixels (multiple of 64)
IMG_H, 128, frame height in pixels (multiple of 64)
ADDR_W, 14, dout_addr width; must be >= clog2(IMG_W*IMG_H)
XY_W, 4, width of the lcu_x/lcu_y ports

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_en  in  1  pixel valid; sampled only while busy=0
din  in  PIX_W  input pixel
ipf_type  in  2  0=off (pass-through), 1=band offset, 2/3=reserved (pass-through)
ipf_band_pos  in  5  first band of the 4-band window
ipf_wo_class  in  1  1=apply offset0 to every pixel, ignoring band
ipf_offset  in  16  four signed 4-bit offsets: [15:12]=o0 .. [3:0]=o3
lcu_x  in  XY_W  LCU column index
lcu_y  in  XY_W  LCU row index
lcu_size  in  2  0=16, 1=32, 2=64, 3=reserved (treated as 16)
busy  out  1  1=upstream must not present pixels
out_en  out  1  dout/dout_addr valid this cycle
dout  out  PIX_W  filtered pixel
dout_addr  out  ADDR_W  absolute raster address
finish  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (reset=0, async): all counters, pipeline registers and latched parameters cleared. busy=0, out_en=0, dout=0, dout_addr=0, finish=0.
- Reset mid-frame: all in-flight pixels are discarded. After release the block starts a new frame at LCU pixel 0.
- Accept rule: a pixel is accepted on a rising edge with in_en=1 and busy=0.
- Parameter latch: on acceptance of LCU pixel 0 (px=py=0), latch ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y and S = size(lcu_size). Changes to these inputs at any other pixel are ignored.
- Pixel counters: px increments per accepted pixel and wraps at S-1 to 0; py then increments. The LCU ends when px=S-1 and py=S-1.
- Address: dout_addr = (lcu_y*S + py)*IMG_W + lcu_x*S + px, truncated to ADDR_W.
- Band: band = din >> (PIX_W-5). k = (band - band_pos) mod 32.
  - BO pixels with k<4 receive offset ok.
  - With wo_class=1, every pixel receives o0.
- Offset scaling: the offset is sign-extended, then shifted left by (PIX_W-8).
- Result: the sum is clipped to [0, 2^PIX_W-1]. Types 0, 2 and 3 pass din through unchanged.
- Pipeline: 2 stages.
  - S1 registers din, band match, offset and address.
  - S2 adds and clips.
  - out_en is asserted exactly 2 cycles after acceptance, one output per accepted pixel, in order.
- busy rules:
  - LCU end: busy=1 for exactly 1 cycle after the last pixel of an LCU is accepted (parameter-reload window).
  - Frame end: once IMG_W*IMG_H pixels have been accepted, busy stays 1 until reset.
- finish: a 1-cycle pulse on the cycle after out_en for the final frame pixel.
- Band window wrap: band_pos=30 covers bands 30, 31, 0, 1.
- Simultaneous events:
  - Last LCU pixel accepted together with the next in_en: the pixel presented during the busy cycle is not accepted; upstream re-presents it.
  - finish and out_en are never high together.

Test Plan:
1. Reset, then LCU(0,0), size 16, type 0, din=0x80 for all pixels -> 256 outputs of 0x80; addr sequence 0,1..15,128,..,1935; busy pulses 1 cycle after pixel 255.
2. Type 1, band_pos=16, offset=0x7F1C, din=0x80 (band 16) -> dout=0x87. din=0x98 (band 19): o3=0xC=-4 -> dout=0x94. din=0x40 (band 8) -> 0x40.
3. Clipping: din=0xFF, band_pos=31, o0=+7 -> 0xFF. din=0x02, band_pos=0, o0=-8 -> 0x00.
4. Wrap: band_pos=30, offset=0x1234, din=0x08 (band 1) -> 0x0C. ipf_wo_class=1 with offset 0x3000, din=0x40 -> 0x43.
5. PIX_W=10, lcu_size=2, lcu_x=1, lcu_y=1, o0=+1, din=0x200 matched -> dout=0x204, first dout_addr=64*128+64=8256.
6. Full 128x128 frame of 16x16 LCUs fed with in_en gated by !busy -> 16384 outputs, no address repeats, finish pulses once, busy stays 1. Reset asserted at pixel 1000 -> outputs stop, and a restart reproduces scenario 1 addresses.
